// File: rtl/generic_bus_resp_pkg.sv
// Shared types and constants for the generic bus SRAM responder.
package generic_bus_resp_pkg;

  // Responder FSM: IDLE waits for a request, WAIT counts down to completion.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_t;

  // Read data returned for any address outside the served window.
  localparam logic [31:0] BAD_DATA = 32'hBAD1BAD1;

  // Legal range of the acceptance-to-completion latency (4-bit counter).
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

endpackage

// File: rtl/generic_bus_resp_mem.sv
// DEPTH_WORDS x 32 synchronous array: per-byte write enables, one registered read port.
module generic_bus_resp_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write: only lanes with be[i]=1 are updated.
  // NOTE: the array has no reset on purpose; contents survive RST and it maps onto plain SRAM.
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read; the word is held until the next enabled read.
  always_ff @(posedge CLK) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/generic_bus_sram_responder.sv
// Fixed-latency SRAM responder: accepts one read or write, completes LATENCY cycles later.
module generic_bus_sram_responder
  import generic_bus_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] rdata
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  // Parameter sanity checks at elaboration.
  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("generic_bus_sram_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("generic_bus_sram_responder: DEPTH_WORDS must be a power of two >= 2");
  end

  resp_state_t   state;
  logic [3:0]    cnt;
  logic          op_write;
  logic          op_read;
  logic          in_range_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   mem_rdata;

  // Address decode: byte offset from the base, word index, and window check.
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          accept;
  logic          mem_we;

  assign offset   = addr - BASE_ADDR;
  assign idx      = offset[AW+1:2];
  assign in_range = (offset >> (AW + 2)) == 32'd0;
  assign accept   = (state == IDLE) && (ren || wen);
  // A write commits on the completion edge only; a reset on that edge cancels it.
  assign mem_we   = (state == WAIT) && (cnt == 4'd0) && op_write && in_range_q && !RST;

  // Request FSM with latched request fields and registered busy.
  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      busy       <= 1'b1;
      op_write   <= 1'b0;
      op_read    <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ren || wen) begin
            state      <= WAIT;
            cnt        <= CNT_LOAD;
            op_write   <= wen;
            op_read    <= ren && !wen;
            in_range_q <= in_range;
            idx_q      <= idx;
            wdata_q    <= wdata;
            be_q       <= byte_en;
            busy       <= (CNT_LOAD != 4'd0);
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b1;
          end else if (!(ren || wen)) begin
            // Initiator withdrew the request: abort with no completion and no write.
            state <= IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b1;
          end else begin
            cnt  <= cnt - 4'd1;
            busy <= (cnt != 4'd1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Read data is driven only in a read's completion cycle (busy low).
  assign rdata = (!busy && op_read) ? (in_range_q ? mem_rdata : BAD_DATA) : 32'd0;

  generic_bus_resp_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .CLK  (CLK),
    .we   (mem_we),
    .be   (be_q),
    .waddr(idx_q),
    .wdata(wdata_q),
    .re   (accept),
    .raddr(idx),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_generic_bus_sram_responder.sv
// Directed bench for generic_bus_sram_responder at LATENCY 2, 3 and 1.
module tb_generic_bus_sram_responder;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Index 0: LATENCY=2, index 1: LATENCY=3, index 2: LATENCY=1.
  logic [2:0]       rst_v;
  logic [2:0]       ren_v;
  logic [2:0]       wen_v;
  logic [2:0][3:0]  be_v;
  logic [2:0][31:0] addr_v;
  logic [2:0][31:0] wdata_v;
  logic [2:0]       busy_v;
  logic [2:0][31:0] rdata_v;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  generic_bus_sram_responder #(.BASE_ADDR(32'h80000000), .DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
    .CLK(CLK), .RST(rst_v[0]), .ren(ren_v[0]), .wen(wen_v[0]), .byte_en(be_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .busy(busy_v[0]), .rdata(rdata_v[0]));

  generic_bus_sram_responder #(.BASE_ADDR(32'h80000000), .DEPTH_WORDS(1024), .LATENCY(3)) u_lat3 (
    .CLK(CLK), .RST(rst_v[1]), .ren(ren_v[1]), .wen(wen_v[1]), .byte_en(be_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .busy(busy_v[1]), .rdata(rdata_v[1]));

  generic_bus_sram_responder #(.BASE_ADDR(32'h80000000), .DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
    .CLK(CLK), .RST(rst_v[2]), .ren(ren_v[2]), .wen(wen_v[2]), .byte_en(be_v[2]),
    .addr(addr_v[2]), .wdata(wdata_v[2]), .busy(busy_v[2]), .rdata(rdata_v[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling/driving.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One access starting in an IDLE cycle. Checks busy stays high until exactly
  // LATENCY cycles after acceptance, the completion rdata, and the IDLE cycle after.
  // keep=1 holds ren/wen into the next IDLE cycle; scramble=1 perturbs addr/wdata/byte_en
  // right after acceptance.
  task automatic access(input int d, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_rd,
                        input bit keep, input bit scramble, input string tag);
    int l = lat_of(d);
    ren_v[d]   = rd;
    wen_v[d]   = wr;
    addr_v[d]  = a;
    wdata_v[d] = wd;
    be_v[d]    = be;
    check({tag, "/idle_busy"}, 32'(busy_v[d]), 32'd1);
    step();
    if (scramble) begin
      addr_v[d]  = a ^ 32'h4;
      wdata_v[d] = ~wd;
      be_v[d]    = ~be;
    end
    for (int k = 1; k < l; k++) begin
      check($sformatf("%s/wait_busy_c%0d", tag, k), 32'(busy_v[d]), 32'd1);
      check($sformatf("%s/wait_rdata_c%0d", tag, k), rdata_v[d], 32'd0);
      step();
    end
    check({tag, "/done_busy"}, 32'(busy_v[d]), 32'd0);
    check({tag, "/done_rdata"}, rdata_v[d], exp_rd);
    if (!keep) begin
      ren_v[d] = 1'b0;
      wen_v[d] = 1'b0;
    end
    step();
    check({tag, "/after_busy"}, 32'(busy_v[d]), 32'd1);
    check({tag, "/after_rdata"}, rdata_v[d], 32'd0);
  endtask

  initial begin
    rst_v   = '1;
    ren_v   = '0;
    wen_v   = '0;
    be_v    = '0;
    addr_v  = '0;
    wdata_v = '0;
    step();
    step();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d/busy", d), 32'(busy_v[d]), 32'd1);
      check($sformatf("reset%0d/rdata", d), rdata_v[d], 32'd0);
    end
    rst_v = '0;
    step();

    // LATENCY=2: full-word write then read back, including an unaligned address.
    access(0, 1, 0, 32'h80000010, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, "wr_deadbeef");
    access(0, 0, 1, 32'h80000010, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, "rd_deadbeef");
    access(0, 0, 1, 32'h80000013, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, "rd_unaligned");

    // Partial byte-lane write.
    access(0, 1, 0, 32'h80000020, 32'h11223344, 4'hF, 32'h0, 0, 0, "wr_base_word");
    access(0, 1, 0, 32'h80000020, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0, "wr_partial");
    access(0, 0, 1, 32'h80000020, 32'h0, 4'h0, 32'h11BB33DD, 0, 0, "rd_partial");

    // Out-of-range read below base and write just past the top (aliases word 0 if undecoded).
    access(0, 1, 0, 32'h80000000, 32'h01020304, 4'hF, 32'h0, 0, 0, "wr_word0");
    access(0, 0, 1, 32'h7FFFFFFC, 32'h0, 4'h0, 32'hBAD1BAD1, 0, 0, "rd_below_base");
    access(0, 1, 0, 32'h80001000, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0, "wr_above_top");
    access(0, 0, 1, 32'h80000000, 32'h0, 4'h0, 32'h01020304, 0, 0, "rd_word0_intact");
    access(0, 1, 0, 32'h80000FFC, 32'hFEEDFACE, 4'hF, 32'h0, 0, 0, "wr_last_word");
    access(0, 0, 1, 32'h80000FFC, 32'h0, 4'h0, 32'hFEEDFACE, 0, 0, "rd_last_word");

    // ren and wen together behave as a write with rdata=0.
    access(0, 1, 1, 32'h80000030, 32'h55AA55AA, 4'hF, 32'h0, 0, 0, "rw_both");
    access(0, 0, 1, 32'h80000030, 32'h0, 4'h0, 32'h55AA55AA, 0, 0, "rd_rw_both");

    // Inputs changed during WAIT must not affect the latched request.
    access(0, 1, 0, 32'h80000044, 32'h00000000, 4'hF, 32'h0, 0, 0, "wr_neighbor");
    access(0, 1, 0, 32'h80000040, 32'h13579BDF, 4'hF, 32'h0, 0, 1, "wr_scramble");
    access(0, 0, 1, 32'h80000040, 32'h0, 4'h0, 32'h13579BDF, 0, 0, "rd_scramble");
    access(0, 0, 1, 32'h80000044, 32'h0, 4'h0, 32'h00000000, 0, 0, "rd_neighbor");

    // Reset pulsed mid-WAIT of a write: access cancelled, memory keeps the old word.
    access(0, 1, 0, 32'h80000050, 32'h0F0F0F0F, 4'hF, 32'h0, 0, 0, "wr_old_word");
    wen_v[0]   = 1'b1;
    addr_v[0]  = 32'h80000050;
    wdata_v[0] = 32'h12345678;
    be_v[0]    = 4'hF;
    check("rst_mid/idle_busy", 32'(busy_v[0]), 32'd1);
    step();
    check("rst_mid/wait_busy", 32'(busy_v[0]), 32'd1);
    rst_v[0] = 1'b1;
    step();
    check("rst_mid/rst_busy", 32'(busy_v[0]), 32'd1);
    check("rst_mid/rst_rdata", rdata_v[0], 32'd0);
    rst_v[0] = 1'b0;
    wen_v[0] = 1'b0;
    step();
    check("rst_mid/post_busy", 32'(busy_v[0]), 32'd1);
    check("rst_mid/post_rdata", rdata_v[0], 32'd0);
    step();
    check("rst_mid/post2_busy", 32'(busy_v[0]), 32'd1);
    access(0, 0, 1, 32'h80000050, 32'h0, 4'h0, 32'h0F0F0F0F, 0, 0, "rd_after_rst");

    // LATENCY=3: abort a write by dropping ren/wen one cycle after acceptance.
    access(1, 1, 0, 32'h80000060, 32'h00000000, 4'hF, 32'h0, 0, 0, "l3_wr_zero");
    wen_v[1]   = 1'b1;
    addr_v[1]  = 32'h80000060;
    wdata_v[1] = 32'h77777777;
    be_v[1]    = 4'hF;
    check("abort/idle_busy", 32'(busy_v[1]), 32'd1);
    step();
    check("abort/wait_busy", 32'(busy_v[1]), 32'd1);
    wen_v[1] = 1'b0;
    step();
    check("abort/dropped_busy", 32'(busy_v[1]), 32'd1);
    check("abort/dropped_rdata", rdata_v[1], 32'd0);
    access(1, 0, 1, 32'h80000060, 32'h0, 4'h0, 32'h00000000, 0, 0, "abort_next_rd");

    // LATENCY=1: back-to-back writes then reads with the request held continuously.
    access(2, 1, 0, 32'h80000100, 32'hA0A0A0A0, 4'hF, 32'h0, 1, 0, "l1_wr0");
    access(2, 1, 0, 32'h80000104, 32'hB1B1B1B1, 4'hF, 32'h0, 1, 0, "l1_wr1");
    access(2, 1, 0, 32'h80000108, 32'hC2C2C2C2, 4'hF, 32'h0, 1, 0, "l1_wr2");
    access(2, 0, 1, 32'h80000108, 32'h0, 4'h0, 32'hC2C2C2C2, 1, 0, "l1_rd2");
    access(2, 0, 1, 32'h80000100, 32'h0, 4'h0, 32'hA0A0A0A0, 1, 0, "l1_rd0");
    access(2, 0, 1, 32'h80000104, 32'h0, 4'h0, 32'hB1B1B1B1, 0, 0, "l1_rd1");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/generic_bus_sram_responder.md
GENERIC_BUS_SRAM_RESPONDER -- requirements
Module: generic_bus_sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h80000000, meaning the first byte address served.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words stored (power of two, >=2).
REQ-003 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to the completion cycle (range 1..15).
REQ-004 SHALL have port CLK, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RST, input, 1, a synchronous, active-high reset.
REQ-006 SHALL have port ren, input, 1, the initiator read request.
REQ-007 SHALL have port wen, input, 1, the initiator write request.
REQ-008 SHALL have port byte_en, input, 4, the byte-lane enables for writes.
REQ-009 SHALL have port addr, input, 32, the byte address.
REQ-010 SHALL have port wdata, input, 32, the write data.
REQ-011 SHALL have port busy, output, 1, asserted high except in the completion cycle.
REQ-012 SHALL have port rdata, output, 32, the read data, valid only in a read's completion cycle.

Function
REQ-013 SHALL implement FSM states IDLE and WAIT, with a 4-bit down-counter cnt.
REQ-014 SHALL accept a request in IDLE when ren|wen=1: latch op, word index and wdata/byte_en, load cnt=LATENCY-1, and go to WAIT.
REQ-015 SHALL signal completion when in WAIT and cnt==0: drive busy=0 for exactly that cycle, then return to IDLE on the next edge.
REQ-016 SHALL produce the completion cycle exactly LATENCY cycles after the acceptance cycle (LATENCY=1 gives busy=0 in the cycle after acceptance).
REQ-017 SHALL decrement cnt by one per cycle in WAIT while cnt!=0.
REQ-018 SHALL accept a new request in IDLE on the cycle after a completion, giving one access per LATENCY+1 cycles.
REQ-019 SHALL commit a write at the completion-cycle edge, updating only the byte lanes with byte_en[i]=1; other lanes keep their old value.
REQ-020 SHALL drive rdata in the completion cycle from a register holding the array word read at acceptance; a write completing the cycle before gives the post-write value.
REQ-021 SHALL service a request with ren=1 and wen=1 as a write, with rdata=0.
REQ-022 SHALL compute the word index as (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2], ignoring addr[1:0].
REQ-023 SHALL treat addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) as out of range: it completes with normal timing, writes are dropped, and reads return 32'hBAD1BAD1.
REQ-024 SHALL abort when ren and wen both drop during WAIT: return to IDLE, commit no write and produce no completion cycle.
REQ-025 SHALL ignore changes to addr, wdata or byte_en during WAIT, using only the values latched at acceptance.
REQ-026 SHALL drive rdata=0 in every cycle other than a read completion.

Reset
REQ-027 SHALL, while RST=1 at an edge, force FSM=IDLE, cnt=0, busy=1, rdata=0 and clear the latched request.
REQ-028 SHALL cancel any in-flight access when reset is asserted mid-WAIT, with no write committed.
REQ-029 SHALL NOT clear array contents on reset.

Structure
REQ-030 SHALL place the state enum resp_state_t, BAD_DATA=32'hBAD1BAD1 and the LATENCY bounds in package generic_bus_resp_pkg.
REQ-031 SHALL instantiate one sub-module, generic_bus_resp_mem: a DEPTH_WORDS x 32 synchronous array with per-byte write enable and one registered read port.
REQ-032 SHALL assert at elaboration that 1<=LATENCY<=15 and that DEPTH_WORDS is a power of two.

Verification
REQ-033 SHALL cover: LATENCY=2; wen, addr=0x80000010, wdata=0xDEADBEEF, byte_en=4'hF at cycle t -> busy=0 only at t+2; later read of the same address -> rdata=0xDEADBEEF at its completion cycle.
REQ-034 SHALL cover: word holds 0x11223344; write byte_en=4'b0101, wdata=0xAABBCCDD -> subsequent read returns 0x11BB33DD.
REQ-035 SHALL cover: read of addr=0x7FFFFFFC and write of addr=0x80001000 (DEPTH_WORDS=1024) -> read returns 0xBAD1BAD1 with normal timing, and the write leaves memory unchanged.
REQ-036 SHALL cover: ren and wen dropped one cycle after acceptance with LATENCY=3 -> no busy=0 pulse, FSM back in IDLE, and the next request accepted immediately.
REQ-037 SHALL cover: RST pulsed during WAIT of a write of 0x12345678 -> busy=1, rdata=0, and a later read returns the old word.
REQ-038 SHALL cover: back-to-back reads with ren held high and LATENCY=1 -> completions every 2 cycles with correct rdata for each address.
